// File: rtl/gate_bist_ctrl_if.sv
// gate_bist_ctrl_if: BIST control/status bus plus the CUT pattern/response pair.
// slave = BIST sequencer side, master = test controller / CUT side.
interface gate_bist_ctrl_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            abort;
  logic [N_IN-1:0] pattin;
  logic            pattout;
  logic            busy;
  logic            done;
  logic            fail;
  logic [N_IN:0]   fail_cnt;
  logic [N_IN-1:0] fail_pat;
  logic [7:0]      signature;

  modport slave (
    input  start, abort, pattout,
    output pattin, busy, done, fail, fail_cnt, fail_pat, signature
  );

  modport master (
    output start, abort, pattout,
    input  pattin, busy, done, fail, fail_cnt, fail_pat, signature
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: exhaustive BIST sequencer for a small combinational CUT.
// Walks every input pattern, holds each for SETTLE cycles, captures the
// response, compares against EXP_TT and counts mismatches.
// Optional MISR signature compaction: define GATE_BIST_MISR_EN.
module gate_bist_ctrl #(
  parameter int                        N_IN   = 2,
  parameter int                        SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]      EXP_TT = 4'b1001
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_bist_ctrl_if.slave    bus
);

  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] PAT_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic [N_IN-1:0] pattin;
  logic [N_IN:0]   fail_cnt;
  logic [N_IN-1:0] fail_pat;
  logic            mismatch;

  assign mismatch = (bus.pattout != EXP_TT[pattin]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state: abort beats both the settle expiry and the final capture
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (bus.start) nxt = S_SETTLE;
      S_SETTLE: begin
        if (bus.abort)             nxt = S_IDLE;
        else if (cnt == CNT_LAST)  nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (bus.abort)               nxt = S_IDLE;
        else if (pattin == PAT_LAST) nxt = S_DONE;
        else                         nxt = S_SETTLE;
      end
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Pattern/counter/result datapath; an aborted cycle leaves results untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pattin   <= '0;
      fail_cnt <= '0;
      fail_pat <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt      <= '0;
            pattin   <= '0;
            fail_cnt <= '0;
            fail_pat <= '0;
          end
        end
        S_SETTLE: begin
          if (bus.abort || cnt == CNT_LAST) cnt <= '0;
          else                              cnt <= cnt + 1'b1;
        end
        S_CAPTURE: begin
          if (!bus.abort) begin
            if (mismatch) begin
              fail_cnt <= fail_cnt + 1'b1;
              if (fail_cnt == '0) fail_pat <= pattin;
            end
            if (pattin != PAT_LAST) pattin <= pattin + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_BIST_MISR_EN
  logic [7:0] sig;

  // MISR over x^8+x^4+x^3+x^2+1, folding in one response bit per capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (state == S_IDLE && bus.start) begin
      sig <= '0;
    end else if (state == S_CAPTURE && !bus.abort) begin
      sig <= {sig[6:0], 1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {7'b0, bus.pattout};
    end
  end

  assign bus.signature = sig;
`else
  assign bus.signature = 8'h00;
`endif

  assign bus.pattin   = pattin;
  assign bus.fail_cnt = fail_cnt;
  assign bus.fail_pat = fail_pat;
  assign bus.fail     = (fail_cnt != '0);
  assign bus.busy     = (state == S_SETTLE) || (state == S_CAPTURE);
  assign bus.done     = (state == S_DONE);

endmodule
